// File: rtl/ft_fifo_pkg.sv
// rtl/ft_fifo_pkg.sv - shared widths and bus FSM encoding for the FT600 FIFO slave
package ft_fifo_pkg;

   localparam int FT_DW  = 16;
   localparam int FT_BEW = 2;

   // Bus-side FSM of the slave: idle, one-cycle turnaround, driving reads, sinking writes.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TURN = 2'd1,
      ST_RD   = 2'd2,
      ST_WR   = 2'd3
   } bus_state_e;

endpackage

// File: rtl/ft_sfifo.sv
// rtl/ft_sfifo.sv - synchronous first-word fall-through FIFO with count and next-head outputs
module ft_sfifo #(
   parameter int W  = 18,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  head_next,
   output logic [AW:0]   cnt,
   output logic [AW:0]   cnt_next
);

   localparam int            DEPTH    = 1 << AW;
   localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full, empty, push_ok, pop_ok;

   // Accept/advance logic; head_next is the word at the head once this edge has taken effect,
   // bypassing the write port when the incoming word lands exactly at the new head slot.
   always_comb begin
      full     = (cnt_q == CNT_FULL);
      empty    = (cnt_q == '0);
      push_ok  = push & ~full;
      pop_ok   = pop & ~empty;
      wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
         head_next = wdata;
      end else begin
         head_next = mem_q[rd_ptr_d];
      end
   end

   // Storage array; not reset, the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointer and occupancy registers; reset flushes the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign cnt      = cnt_q;
   assign cnt_next = cnt_d;

endmodule

// File: rtl/ft_fifo_slv.sv
// rtl/ft_fifo_slv.sv - FT600 245-sync FIFO slave emulator with host push/pop ports
module ft_fifo_slv
   import ft_fifo_pkg::*;
#(
   parameter int DW    = FT_DW,
   parameter int BEW   = FT_BEW,
   parameter int DN_AW = 10,
   parameter int UP_AW = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           wr_n,
   input  logic           rd_n,
   input  logic           oe_n,
   input  logic [DW-1:0]  data_i,
   input  logic [BEW-1:0] be_i,
   output logic [DW-1:0]  data_o,
   output logic [BEW-1:0] be_o,
   output logic           data_oe,
   output logic           rxf_n,
   output logic           txe_n,
   input  logic           rxf_hold,
   input  logic           txe_hold,
   input  logic           h_push,
   input  logic [DW-1:0]  h_wdata,
   input  logic [BEW-1:0] h_be,
   output logic           h_full,
   input  logic           h_pop,
   output logic [DW-1:0]  h_rdata,
   output logic [BEW-1:0] h_rbe,
   output logic           h_empty,
   output logic           proto_err
);

   localparam int            EW      = DW + BEW;
   localparam logic [DN_AW:0] DN_FULL = {1'b1, {DN_AW{1'b0}}};
   localparam logic [UP_AW:0] UP_FULL = {1'b1, {UP_AW{1'b0}}};

   bus_state_e     state_q, state_d;
   logic           data_oe_q, data_oe_d;
   logic [DW-1:0]  data_o_q, data_o_d;
   logic [BEW-1:0] be_o_q, be_o_d;
   logic           rxf_n_q, rxf_n_d;
   logic           txe_n_q, txe_n_d;
   logic           proto_err_q, proto_err_d;
   logic [EW-1:0]  h_rword_q, h_rword_d;

   logic           dn_pop, up_push;
   logic [EW-1:0]  dn_head_next, up_head_next;
   logic [DN_AW:0] dn_cnt, dn_cnt_next;
   logic [UP_AW:0] up_cnt, up_cnt_next;

   // Downstream: host writes, bus master reads.
   ft_sfifo #(.W(EW), .AW(DN_AW)) u_dn_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (h_push),
      .wdata     ({h_be, h_wdata}),
      .pop       (dn_pop),
      .head_next (dn_head_next),
      .cnt       (dn_cnt),
      .cnt_next  (dn_cnt_next)
   );

   // Upstream: bus master writes, host reads.
   ft_sfifo #(.W(EW), .AW(UP_AW)) u_up_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (up_push),
      .wdata     ({be_i, data_i}),
      .pop       (h_pop),
      .head_next (up_head_next),
      .cnt       (up_cnt),
      .cnt_next  (up_cnt_next)
   );

   // Bus FSM next state, read-data staging, transfer strobes, flags and protocol checks.
   always_comb begin
      state_d     = state_q;
      data_oe_d   = data_oe_q;
      data_o_d    = data_o_q;
      be_o_d      = be_o_q;
      proto_err_d = proto_err_q;
      h_rword_d   = up_head_next;

      // A pop only happens while the slave is advertising data, so it never underflows.
      dn_pop  = (state_q == ST_RD) & ~rd_n & ~rxf_n_q;
      up_push = ~wr_n & ~txe_n_q & oe_n;

      case (state_q)
         ST_IDLE: begin
            if (!oe_n) begin
               state_d = ST_TURN;
            end else if (!wr_n) begin
               state_d = ST_WR;
            end
         end
         ST_TURN: begin
            state_d            = ST_RD;
            data_oe_d          = 1'b1;
            {be_o_d, data_o_d} = dn_head_next;
         end
         ST_RD: begin
            // Present the head as it will be after this edge so back-to-back pops see successive words.
            {be_o_d, data_o_d} = dn_head_next;
            if (oe_n) begin
               state_d   = ST_IDLE;
               data_oe_d = 1'b0;
            end
         end
         ST_WR: begin
            if (wr_n) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            data_oe_d = 1'b0;
         end
      endcase

      if (!wr_n && txe_n_q) begin
         proto_err_d = 1'b1;
      end
      if (!wr_n && data_oe_q) begin
         proto_err_d = 1'b1;
      end
      if (!rd_n && ((state_q == ST_IDLE) || (state_q == ST_WR))) begin
         proto_err_d = 1'b1;
      end
      if (!oe_n && (state_q == ST_WR)) begin
         proto_err_d = 1'b1;
      end

      rxf_n_d = rxf_hold | (dn_cnt_next == '0);
      txe_n_d = txe_hold | (up_cnt_next == UP_FULL);
   end

   // Bus-side registers; reset drops data_oe and returns the FSM to idle on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         data_oe_q   <= 1'b0;
         data_o_q    <= '0;
         be_o_q      <= '0;
         rxf_n_q     <= 1'b1;
         txe_n_q     <= 1'b1;
         proto_err_q <= 1'b0;
         h_rword_q   <= '0;
      end else begin
         state_q     <= state_d;
         data_oe_q   <= data_oe_d;
         data_o_q    <= data_o_d;
         be_o_q      <= be_o_d;
         rxf_n_q     <= rxf_n_d;
         txe_n_q     <= txe_n_d;
         proto_err_q <= proto_err_d;
         h_rword_q   <= h_rword_d;
      end
   end

   assign data_o             = data_o_q;
   assign be_o               = be_o_q;
   assign data_oe            = data_oe_q;
   assign rxf_n              = rxf_n_q;
   assign txe_n              = txe_n_q;
   assign proto_err          = proto_err_q;
   assign {h_rbe, h_rdata}   = h_rword_q;
   assign h_full             = (dn_cnt == DN_FULL);
   assign h_empty            = (up_cnt == '0);

endmodule

// File: tb/tb_ft_fifo_slv.sv
// tb/tb_ft_fifo_slv.sv - directed scoreboard bench for the FT600 FIFO slave
module tb_ft_fifo_slv;

   logic        clk;
   logic        rst;
   logic        wr_n, rd_n, oe_n;
   logic [15:0] data_i;
   logic [1:0]  be_i;
   logic [15:0] data_o;
   logic [1:0]  be_o;
   logic        data_oe, rxf_n, txe_n;
   logic        rxf_hold, txe_hold;
   logic        h_push;
   logic [15:0] h_wdata;
   logic [1:0]  h_be;
   logic        h_full;
   logic        h_pop;
   logic [15:0] h_rdata;
   logic [1:0]  h_rbe;
   logic        h_empty;
   logic        proto_err;

   int errors = 0;
   int checks = 0;

   logic [17:0] dn_q[$];
   logic [17:0] up_q[$];
   logic [17:0] e;

   ft_fifo_slv dut (
      .clk       (clk),
      .rst       (rst),
      .wr_n      (wr_n),
      .rd_n      (rd_n),
      .oe_n      (oe_n),
      .data_i    (data_i),
      .be_i      (be_i),
      .data_o    (data_o),
      .be_o      (be_o),
      .data_oe   (data_oe),
      .rxf_n     (rxf_n),
      .txe_n     (txe_n),
      .rxf_hold  (rxf_hold),
      .txe_hold  (txe_hold),
      .h_push    (h_push),
      .h_wdata   (h_wdata),
      .h_be      (h_be),
      .h_full    (h_full),
      .h_pop     (h_pop),
      .h_rdata   (h_rdata),
      .h_rbe     (h_rbe),
      .h_empty   (h_empty),
      .proto_err (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; wr_n = 1'b1; rd_n = 1'b1; oe_n = 1'b1;
      data_i = '0; be_i = '0; rxf_hold = 1'b0; txe_hold = 1'b0;
      h_push = 1'b0; h_wdata = '0; h_be = '0; h_pop = 1'b0;

      // 1: reset state
      repeat (3) tick();
      chk("rst_rxf_n", 32'(rxf_n), 32'd1);
      chk("rst_txe_n", 32'(txe_n), 32'd1);
      chk("rst_data_oe", 32'(data_oe), 32'd0);
      chk("rst_data_o", 32'({be_o, data_o}), 32'd0);
      chk("rst_h_full", 32'(h_full), 32'd0);
      chk("rst_h_empty", 32'(h_empty), 32'd1);
      chk("rst_proto_err", 32'(proto_err), 32'd0);
      rst = 1'b0;
      tick();
      chk("rel_txe_n", 32'(txe_n), 32'd0);
      chk("rel_rxf_n", 32'(rxf_n), 32'd1);

      // 2: host pushes four words, master reads them back
      for (int i = 1; i <= 4; i++) begin
         h_push = 1'b1; h_wdata = 16'(i); h_be = 2'b11;
         dn_q.push_back({2'b11, 16'(i)});
         tick();
      end
      h_push = 1'b0;
      chk("rd_rxf_low", 32'(rxf_n), 32'd0);
      oe_n = 1'b0;
      tick();
      chk("rd_turn_oe", 32'(data_oe), 32'd0);
      tick();
      chk("rd_data_oe", 32'(data_oe), 32'd1);
      rd_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         e = dn_q.pop_front();
         chk("rd_word", 32'({be_o, data_o}), 32'(e));
         tick();
      end
      rd_n = 1'b1;
      chk("rd_rxf_empty", 32'(rxf_n), 32'd1);
      oe_n = 1'b1;
      tick();
      chk("rd_oe_drop", 32'(data_oe), 32'd0);
      chk("rd_no_err", 32'(proto_err), 32'd0);

      // 3: two master writes, host pops them
      wr_n = 1'b0; data_i = 16'hA5A5; be_i = 2'b01;
      up_q.push_back({2'b01, 16'hA5A5});
      tick();
      data_i = 16'h5A5A; be_i = 2'b11;
      up_q.push_back({2'b11, 16'h5A5A});
      tick();
      wr_n = 1'b1;
      tick();
      chk("wr_not_empty", 32'(h_empty), 32'd0);
      for (int i = 0; i < 2; i++) begin
         e = up_q.pop_front();
         chk("wr_host_word", 32'({h_rbe, h_rdata}), 32'(e));
         h_pop = 1'b1;
         tick();
         h_pop = 1'b0;
      end
      chk("wr_empty", 32'(h_empty), 32'd1);
      chk("wr_no_err", 32'(proto_err), 32'd0);

      // 4: fill upstream, then one write too many
      wr_n = 1'b0; be_i = 2'b11;
      for (int i = 0; i < 1024; i++) begin
         data_i = 16'(i + 16'h0100);
         up_q.push_back({2'b11, 16'(i + 16'h0100)});
         tick();
         if (i == 1022) chk("fill_txe_open", 32'(txe_n), 32'd0);
      end
      chk("fill_txe_full", 32'(txe_n), 32'd1);
      chk("fill_no_err", 32'(proto_err), 32'd0);
      data_i = 16'hDEAD;
      tick();
      wr_n = 1'b1;
      chk("fill_overrun_err", 32'(proto_err), 32'd1);
      tick();
      for (int i = 0; i < 1024; i++) begin
         e = up_q.pop_front();
         chk("fill_host_word", 32'({h_rbe, h_rdata}), 32'(e));
         h_pop = 1'b1;
         tick();
         if (i == 0) chk("fill_txe_reopen", 32'(txe_n), 32'd0);
      end
      h_pop = 1'b0;
      chk("fill_drained", 32'(h_empty), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      chk("fill_rst_err", 32'(proto_err), 32'd0);

      // 5: simultaneous host push and bus pop with one word held
      h_push = 1'b1; h_wdata = 16'h1111; h_be = 2'b11;
      dn_q.push_back({2'b11, 16'h1111});
      tick();
      h_push = 1'b0;
      oe_n = 1'b0;
      tick();
      tick();
      rd_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         h_push = 1'b1; h_wdata = 16'(16'h2000 + k); h_be = 2'b10;
         dn_q.push_back({2'b10, 16'(16'h2000 + k)});
         e = dn_q.pop_front();
         chk("sim_word", 32'({be_o, data_o}), 32'(e));
         tick();
         chk("sim_rxf_low", 32'(rxf_n), 32'd0);
      end
      h_push = 1'b0;
      e = dn_q.pop_front();
      chk("sim_last_word", 32'({be_o, data_o}), 32'(e));
      tick();
      rd_n = 1'b1;
      chk("sim_rxf_empty", 32'(rxf_n), 32'd1);
      oe_n = 1'b1;
      tick();
      chk("sim_no_err", 32'(proto_err), 32'd0);

      // 6: bus contention, then reset in the middle of a read
      h_push = 1'b1; h_wdata = 16'h3333; h_be = 2'b11;
      tick();
      h_wdata = 16'h4444;
      tick();
      h_push = 1'b0;
      oe_n = 1'b0;
      tick();
      tick();
      chk("cont_data_oe", 32'(data_oe), 32'd1);
      wr_n = 1'b0;
      tick();
      wr_n = 1'b1;
      chk("cont_err", 32'(proto_err), 32'd1);
      rd_n = 1'b0;
      rst = 1'b1;
      tick();
      chk("mid_rst_oe", 32'(data_oe), 32'd0);
      chk("mid_rst_rxf", 32'(rxf_n), 32'd1);
      chk("mid_rst_err", 32'(proto_err), 32'd0);
      rst = 1'b0; rd_n = 1'b1; oe_n = 1'b1;
      tick();
      chk("post_rst_rxf", 32'(rxf_n), 32'd1);
      chk("post_rst_txe", 32'(txe_n), 32'd0);

      // 7: read strobe while idle is a protocol error
      rd_n = 1'b0;
      tick();
      rd_n = 1'b1;
      chk("idle_rd_err", 32'(proto_err), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
